// File: rtl/watch_pkg.sv
// Shared watch definitions: LCD command bytes, mode encoding and the
// frame sequencer state type.
package watch_pkg;

    localparam logic [7:0] LCD_CMD_LINE1 = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE2 = 8'hC0;
    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;

    localparam logic [1:0] MODE_WATCH     = 2'd0;
    localparam logic [1:0] MODE_SET       = 2'd1;
    localparam logic [1:0] MODE_STOPWATCH = 2'd2;
    localparam logic [1:0] MODE_ALARM     = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_FETCH,
        ST_SEND,
        ST_DONE,
        ST_GAP
    } seq_state_e;

endpackage

// File: rtl/lcd_frame_sequencer.sv
// Sweeps the 32 LCD character cells of the selected mode into the LCD driver,
// framing each line with a DDRAM address command. Option: LCD_SEQ_CLEAR_ON_MODE_EN.
module lcd_frame_sequencer
    import watch_pkg::*;
#(
    parameter int NUM_MODES = 4,
    parameter int CHAR_LAT  = 1,
    parameter int FRAME_GAP = 1000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode_next,
    input  logic [8*NUM_MODES-1:0]       char_bus,
    input  logic                         lcd_ready,
    output logic [4:0]                   index,
    output logic [$clog2(NUM_MODES)-1:0] mode,
    output logic                         lcd_valid,
    output logic                         lcd_rs,
    output logic [7:0]                   lcd_data,
    output logic                         frame_done
);

    localparam int MODE_W = $clog2(NUM_MODES);
    localparam logic [1:0]        LAT_LAST  = 2'(CHAR_LAT - 1);
    localparam logic [15:0]       GAP_LAST  = 16'(FRAME_GAP - 1);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

`ifdef LCD_SEQ_CLEAR_ON_MODE_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    seq_state_e  state;
    seq_state_e  state_nxt;
    logic [1:0]  lat_cnt;
    logic [15:0] gap_cnt;
    logic [7:0]  char_q;
    logic        pending;
    logic        clear_q;
    logic        xfer;

    assign xfer = lcd_valid && lcd_ready;

    // NOTE: every register here uses <= so all updates see pre-edge values;
    // blocking assignments would make the result depend on statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            index   <= '0;
            mode    <= '0;
            lat_cnt <= '0;
            gap_cnt <= '0;
            char_q  <= '0;
            pending <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state <= state_nxt;
            // A pulse landing in DONE itself survives into the next frame.
            pending <= (state == ST_DONE) ? mode_next : (pending | mode_next);
            case (state)
                ST_CMD: begin
                    if (xfer) clear_q <= 1'b0;
                end
                ST_FETCH: begin
                    if (lat_cnt == LAT_LAST) begin
                        lat_cnt <= '0;
                        char_q  <= char_bus[{mode, 3'b000} +: 8];
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                ST_SEND: begin
                    if (xfer && index != 5'd31) index <= index + 5'd1;
                end
                ST_DONE: begin
                    index   <= '0;
                    gap_cnt <= '0;
                    if (pending) begin
                        mode    <= (mode == MODE_LAST) ? '0 : mode + 1'b1;
                        clear_q <= CLEAR_EN;
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt  = state;
        lcd_valid  = 1'b0;
        lcd_rs     = 1'b0;
        lcd_data   = 8'h00;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: state_nxt = ST_CMD;
            ST_CMD: begin
                lcd_valid = 1'b1;
                if (clear_q)       lcd_data = LCD_CMD_CLEAR;
                else if (index[4]) lcd_data = LCD_CMD_LINE2;
                else               lcd_data = LCD_CMD_LINE1;
                // The clear command is followed by the line-1 address in CMD.
                if (lcd_ready && !clear_q) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (lat_cnt == LAT_LAST) state_nxt = ST_SEND;
            end
            ST_SEND: begin
                lcd_valid = 1'b1;
                lcd_rs    = 1'b1;
                lcd_data  = char_q;
                if (lcd_ready) begin
                    if (index == 5'd31)      state_nxt = ST_DONE;
                    else if (index == 5'd15) state_nxt = ST_CMD;
                    else                     state_nxt = ST_FETCH;
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_nxt  = (FRAME_GAP == 0) ? ST_CMD : ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = ST_CMD;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Self-checking bench for lcd_frame_sequencer: random ready stalls and mode
// pulses checked against a frame-level transfer model.
module tb_lcd_frame_sequencer;
    import watch_pkg::*;

`ifdef LCD_SEQ_CLEAR_ON_MODE_EN
    localparam bit TB_CLEAR = 1'b1;
`else
    localparam bit TB_CLEAR = 1'b0;
`endif

    typedef logic [8:0] word_q_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        mode_next;
    logic [31:0] char_bus;
    logic        lcd_ready;
    logic [4:0]  index;
    logic [1:0]  mode;
    logic        lcd_valid;
    logic        lcd_rs;
    logic [7:0]  lcd_data;
    logic        frame_done;

    lcd_frame_sequencer #(
        .NUM_MODES(4),
        .CHAR_LAT (1),
        .FRAME_GAP(0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode_next (mode_next),
        .char_bus  (char_bus),
        .lcd_ready (lcd_ready),
        .index     (index),
        .mode      (mode),
        .lcd_valid (lcd_valid),
        .lcd_rs    (lcd_rs),
        .lcd_data  (lcd_data),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Screen generators: each mode shows a fixed 32-character table.
    logic [7:0] screen [4][32];
    always_comb begin
        char_bus = '0;
        for (int m = 0; m < 4; m++) char_bus[8*m +: 8] = screen[m][index];
    end

    int tests = 0;
    int fails = 0;

    word_q_t    xfers;
    bit         hold_pending = 1'b0;
    logic [8:0] hold_word    = '0;
    logic [1:0] prev_mode    = '0;
    logic       prev_done    = 1'b0;
    logic       prev_rst     = 1'b1;
    int stall_checks = 0, stall_viol = 0, mode_viol = 0, done_viol = 0;
    int done_pulses  = 0, frames = 0;

    int exp_mode    = 0;
    bit exp_pending = 1'b0;
    bit exp_clear   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic word_q_t build_frame(int m, bit clr);
        word_q_t q;
        if (clr) q.push_back({1'b0, LCD_CMD_CLEAR});
        q.push_back({1'b0, LCD_CMD_LINE1});
        for (int i = 0; i < 32; i++) begin
            if (i == 16) q.push_back({1'b0, LCD_CMD_LINE2});
            q.push_back({1'b1, screen[m][i]});
        end
        return q;
    endfunction

    // Called at a falling edge: drive inputs for the next rising edge, log the
    // transfer it will perform, then advance to the following falling edge.
    task automatic step(input bit rdy, input bit pulse);
        lcd_ready = rdy;
        mode_next = pulse;
        if (hold_pending) begin
            stall_checks++;
            if (!(lcd_valid && {lcd_rs, lcd_data} == hold_word)) stall_viol++;
        end
        if (lcd_valid && rdy && !rst) xfers.push_back({lcd_rs, lcd_data});
        hold_pending = lcd_valid && !rdy && !rst;
        hold_word    = {lcd_rs, lcd_data};
        prev_mode    = mode;
        prev_done    = frame_done;
        prev_rst     = rst;
        @(negedge clk);
        if (frame_done) done_pulses++;
        if (frame_done && prev_done) done_viol++;
        if (mode != prev_mode && !prev_done && !prev_rst) mode_viol++;
    endtask

    task automatic run_frame(input string tag, input int ready_pct, input int n_pulses,
                             input bit pulse_at_start, output int cycles);
        word_q_t exp;
        bit      done;
        int      n;
        exp = build_frame(exp_mode, exp_clear);
        if (pulse_at_start || n_pulses > 0) exp_pending = 1'b1;
        done   = 1'b0;
        cycles = 0;
        for (int c = 0; c < 4000 && !done; c++) begin
            bit rdy, pulse;
            rdy   = ($urandom_range(99) < ready_pct);
            pulse = (c == 0 && pulse_at_start) || (c >= 2 && c < 2 + 2*n_pulses && c % 2 == 0);
            step(rdy, pulse);
            cycles++;
            if (c == 0) check({tag, "_mode"}, 32'(mode), exp_mode);
            if (frame_done) done = 1'b1;
        end
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_len"}, xfers.size(), exp.size());
        n = (xfers.size() < exp.size()) ? xfers.size() : exp.size();
        for (int i = 0; i < n; i++) check({tag, "_xfer"}, 32'(xfers[i]), 32'(exp[i]));
        xfers.delete();
        if (done) frames++;
        if (exp_pending) begin
            exp_mode    = (exp_mode + 1) % 4;
            exp_clear   = TB_CLEAR;
            exp_pending = 1'b0;
        end else begin
            exp_clear = 1'b0;
        end
    endtask

    initial begin
        int  cyc;
        bit  found;
        for (int i = 0; i < 32; i++) begin
            screen[MODE_WATCH][i] = 8'h40 + 8'(i);
            for (int m = 1; m < 4; m++) screen[m][i] = 8'($urandom);
        end
        rst       = 1'b1;
        lcd_ready = 1'b0;
        mode_next = 1'b0;
        repeat (3) step(1'b0, 1'b0);
        check("rst_index", 32'(index), 0);
        check("rst_mode", 32'(mode), 0);
        check("rst_valid", 32'(lcd_valid), 0);
        check("rst_rs", 32'(lcd_rs), 0);
        check("rst_data", 32'(lcd_data), 0);
        check("rst_done", 32'(frame_done), 0);

        rst = 1'b0;
        step(1'b1, 1'b0);
        check("first_valid", 32'(lcd_valid), 1);
        check("first_word", 32'({lcd_rs, lcd_data}), 32'({1'b0, LCD_CMD_LINE1}));

        run_frame("f1_ready", 100, 0, 1'b0, cyc);
        run_frame("f2_ready", 100, 0, 1'b0, cyc);
        check("f2_cycles", cyc, 67);
        run_frame("f3_stall", 30, 0, 1'b0, cyc);

        for (int i = 0; i < 32; i++)
            for (int m = 1; m < 4; m++) screen[m][i] = 8'($urandom);

        run_frame("f4_pulses", 60, 3, 1'b0, cyc);
        run_frame("f5_mode1", 60, 0, 1'b0, cyc);
        check("f5_end_mode", 32'(mode), 1);
        run_frame("f6_donepulse", 100, 0, 1'b1, cyc);
        run_frame("f7_mode2", 100, 1, 1'b0, cyc);
        run_frame("f8_mode3", 50, 1, 1'b0, cyc);
        run_frame("f9_wrap", 100, 0, 1'b0, cyc);

        // Abort a frame in SEND at index 20 with a mode request outstanding.
        found = 1'b0;
        for (int k = 0; k < 500 && !found; k++) begin
            if (lcd_valid && lcd_rs && index == 5'd20) found = 1'b1;
            else step(1'b1, k == 3);
        end
        check("mid_found", 32'(found), 1);
        rst = 1'b1;
        step(1'b0, 1'b0);
        check("mid_rst_valid", 32'(lcd_valid), 0);
        check("mid_rst_index", 32'(index), 0);
        check("mid_rst_mode", 32'(mode), 0);
        rst = 1'b0;
        xfers.delete();
        exp_mode    = 0;
        exp_pending = 1'b0;
        exp_clear   = 1'b0;
        step(1'b1, 1'b0);
        check("restart_word", 32'({lcd_rs, lcd_data}), 32'({1'b0, LCD_CMD_LINE1}));
        check("restart_index", 32'(index), 0);
        run_frame("f10_restart", 70, 0, 1'b0, cyc);
        run_frame("f11_after", 100, 0, 1'b0, cyc);

        check("stall_seen", 32'(stall_checks > 0), 1);
        check("stall_stable", stall_viol, 0);
        check("mode_in_frame", mode_viol, 0);
        check("done_width", done_viol, 0);
        check("done_count", done_pulses, frames);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd_frame_sequencer.md
# lcd_frame_sequencer

Owns the character LCD refresh path between the per-mode screen generators (watch, set, stopwatch, alarm) and the LCD bus driver. It sweeps the shared 5-bit character `index` from 0 to 31 and samples the 8-bit character from the currently selected mode. Each frame is framed with DDRAM line-address commands and pushed to the LCD driver over a valid/ready handshake. It also arbitrates mode changes so that a new mode takes effect only on a frame boundary.

## Interface
Parameters:
- `NUM_MODES`, 4: number of screen generators on `char_bus`; must be ≥2.
- `CHAR_LAT`, 1: cycles from a stable `index` to a valid character on `char_bus`; range 1–3.
- `FRAME_GAP`, 1000: idle cycles after `frame_done` before the next frame starts; range 0–65535.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; **one clock; reset is synchronous and active-high.**
- `mode_next`  in  1  debounced single-cycle pulse requesting the next mode.
- `char_bus`  in  8·NUM_MODES  flattened characters; mode m occupies bits [8m+7:8m].
- `lcd_ready`  in  1  LCD driver accepts the current word.
- `index`  out  5  character position presented to all screen generators.
- `mode`  out  $clog2(NUM_MODES)  active mode select.
- `lcd_valid`  out  1  word available.
- `lcd_rs`  out  1  0 = command, 1 = data.
- `lcd_data`  out  8  command or character byte.
- `frame_done`  out  1  one-cycle pulse after the 34th transfer of a frame.

## Operation
- Frame = CMD 0x80, DATA for index 0..15, CMD 0xC0, DATA for index 16..31: 34 transfers.
- State machine: IDLE → CMD → FETCH → SEND → (FETCH | CMD | DONE) → GAP → CMD.
  - IDLE: reset state. Goes to CMD on the first edge with `rst` low.
  - CMD: `lcd_rs`=0, `lcd_data`=0x80 when `index`=0, 0xC0 when `index`=16, `lcd_valid`=1. Holds until a transfer occurs, then goes to FETCH.
  - FETCH: `index` stable, `lcd_valid`=0. Waits CHAR_LAT cycles. On the last cycle, captures `char_bus[8*mode +: 8]` and goes to SEND.
  - SEND: `lcd_rs`=1, `lcd_valid`=1. On transfer:
    - `index`=15 → `index`←16, go to CMD.
    - `index`=31 → go to DONE.
    - otherwise `index`++, go to FETCH.
  - DONE: one cycle. `frame_done`=1, `index`←0, pending mode applied, go to GAP.
  - GAP: counts FRAME_GAP cycles (0 = direct), then goes to CMD.
- Transfer = `lcd_valid` && `lcd_ready` at a rising edge. While `lcd_valid`=1 and no transfer has occurred, `lcd_rs` and `lcd_data` are held stable.
- Mode arbitration:
  - A `mode_next` pulse sets a sticky pending flag.
  - Further pulses before DONE are absorbed: at most one advance per frame.
  - In DONE, `mode` ← (mode+1) wrapping NUM_MODES−1→0, and the flag clears.
  - A pulse arriving in the DONE cycle itself stays pending for the next frame.
- `mode` never changes inside a frame, so no torn screens.

## Timing
- Reset values: `index`=0, `mode`=0, `lcd_valid`=0, `lcd_rs`=0, `lcd_data`=0x00, `frame_done`=0, pending=0, state IDLE.
- `rst` asserted mid-handshake drops `lcd_valid` at that edge; the next frame restarts at CMD 0x80.
- With `lcd_ready` tied high, the first `lcd_valid` appears 1 cycle after reset release.
- Per character with ready held high: 1 SEND + CHAR_LAT FETCH cycles.
- Frame length with ready high: 2 + 32·(CHAR_LAT+1) + 1 (DONE) cycles, plus FRAME_GAP.
- `lcd_ready` low stalls indefinitely; no timeout.

## Configuration
- `LCD_SEQ_CLEAR_ON_MODE_EN`
  - Defined: when a mode change is applied in DONE, the next frame is preceded by CMD 0x01 (clear display). The frame then has 35 transfers, and `frame_done` still pulses once.
  - Undefined: frames are always 34 transfers, and a mode change only rewrites characters.

## Structure
- Shared package `watch_pkg`:
  - LCD constants `LCD_CMD_LINE1`=8'h80, `LCD_CMD_LINE2`=8'hC0, `LCD_CMD_CLEAR`=8'h01.
  - The state enum type.
  - Mode encoding constants MODE_WATCH=0, MODE_SET=1, MODE_STOPWATCH=2, MODE_ALARM=3.
- No sub-module: the FSM, the CHAR_LAT counter and the gap counter are local.

## Test plan
- Ready high, CHAR_LAT=1, FRAME_GAP=0, mode 0 drives char = 8'h40+index → 34 transfers in order: 0x80, 0x40..0x4F, 0xC0, 0x50..0x5F; `frame_done` pulses once; frame is 67 cycles.
- Random `lcd_ready` stalls (30% high) → transfer sequence identical to the previous case; `lcd_rs`/`lcd_data` never change while `lcd_valid`=1 and no transfer has occurred.
- Three `mode_next` pulses during one frame → `mode` 0→1 exactly at DONE; next frame's characters come from slice 1; second frame ends with `mode`=1.
- Mode 3, one pulse with NUM_MODES=4 → `mode` wraps to 0 at DONE.
- `rst` pulsed while in SEND at `index`=20 → `lcd_valid`=0 at that edge; first transfer after release is CMD 0x80 with `index`=0.
- `LCD_SEQ_CLEAR_ON_MODE_EN` defined, one mode change → next frame begins 0x01, 0x80 and totals 35 transfers; following frame returns to 34.
